vga_timing_ctrl: RTL and testbench

Sequencing controller for the VGA pixel datapath. Consumes the one-in-four pixel-enable tick from the pixel clock divider and steps horizontal/vertical position counters through active, front-porch, sync and back-porch phases, producing hsync, vsync, display-active and pixel coordinates for the pixel generator. A run/idle handshake starts and stops scanout only on frame boundaries, so a monitor never sees a truncated frame.

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/vga_axis_cnt.sv | 46 ++++
 rtl/vga_timing_ctrl.sv | 137 +++++++++++++
 tb/tb_vga_timing_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 constants, derived
// totals, scan phase and top-level state enums, and a phase decode helper.
package vga_pkg;

   localparam int POS_W = 10;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_t;

   typedef enum logic {ST_IDLE, ST_SCAN} state_t;

   // Map a position on one axis to the phase it falls in; back porch is
   // whatever remains after active, front porch and sync.
   function automatic phase_t phase_of(input logic [POS_W-1:0] pos,
                                       input int act,
                                       input int fp,
                                       input int sync);
      int p;
      p = int'(pos);
      if (p < act)
         return PH_ACTIVE;
      else if (p < act + fp)
         return PH_FP;
      else if (p < act + fp + sync)
         return PH_SYNC;
      else
         return PH_BP;
   endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One scan axis: a wrapping position counter with a look-ahead phase decode
// so the parent can register phase-derived outputs in step with the count.
// The axis total (ACTIVE+FP+SYNC+BP) must fit the 10-bit counter (<= 1024).
module vga_axis_cnt
   import vga_pkg::*;
#(
   parameter int ACTIVE = VGA_H_ACTIVE,
   parameter int FP     = VGA_H_FP,
   parameter int SYNC   = VGA_H_SYNC,
   parameter int BP     = VGA_H_BP
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             step,
   input  logic             clear,
   output logic [POS_W-1:0] count,
   output logic             at_end,
   output phase_t           phase_next
);

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;
   localparam logic [POS_W-1:0] LAST = POS_W'(TOTAL - 1);

   logic [POS_W-1:0] count_next;

   assign at_end = (count == LAST);

   // Next position: clear wins, otherwise step with wrap at the last position.
   always_comb begin
      count_next = count;
      if (clear)
         count_next = '0;
      else if (step)
         count_next = at_end ? '0 : count + POS_W'(1);
      phase_next = phase_of(count_next, ACTIVE, FP, SYNC);
   end

   // Position register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else
         count <= count_next;
   end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing sequencer: steps horizontal/vertical positions on pixel ticks,
// starts and stops scanout only at frame boundaries, and produces registered
// sync/active/coordinate outputs aligned with the current position.
// Optional: define VGA_FRAME_CNT_EN to add an 8-bit wrapping frame counter.
module vga_timing_ctrl
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       pixEn,
   input  logic       run,
   output logic       busy,
   output logic       hsync,
   output logic       vsync,
   output logic       active,
   output logic [9:0] pixX,
   output logic [9:0] pixY,
   output logic       frameStart
`ifdef VGA_FRAME_CNT_EN
   ,output logic [7:0] frameCnt
`endif
);

   state_t state;
   state_t state_next;
   logic   h_step;
   logic   h_clear;
   logic   v_step;
   logic   v_clear;
   logic   h_end;
   logic   v_end;
   logic   start_next;
   phase_t h_phase_next;
   phase_t v_phase_next;

   vga_axis_cnt #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h (
      .clock      (clock),
      .reset      (reset),
      .step       (h_step),
      .clear      (h_clear),
      .count      (pixX),
      .at_end     (h_end),
      .phase_next (h_phase_next)
   );

   vga_axis_cnt #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v (
      .clock      (clock),
      .reset      (reset),
      .step       (v_step),
      .clear      (v_clear),
      .count      (pixY),
      .at_end     (v_end),
      .phase_next (v_phase_next)
   );

   // Next state and counter control; run is only honoured at (0,0) entry points.
   always_comb begin
      state_next = state;
      h_step     = 1'b0;
      h_clear    = 1'b0;
      v_step     = 1'b0;
      v_clear    = 1'b0;
      start_next = 1'b0;
      if (state == ST_IDLE) begin
         h_clear = 1'b1;
         v_clear = 1'b1;
         if (pixEn && run) begin
            state_next = ST_SCAN;
            start_next = 1'b1;
         end
      end else if (pixEn) begin
         h_step = 1'b1;
         if (h_end) begin
            v_step = 1'b1;
            if (v_end) begin
               if (run) begin
                  start_next = 1'b1;
               end else begin
                  state_next = ST_IDLE;
                  h_clear    = 1'b1;
                  v_clear    = 1'b1;
               end
            end
         end
      end
   end

   // State and outputs registered from next-position decode so they line up with pixX/pixY.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         active     <= 1'b0;
         frameStart <= 1'b0;
      end else begin
         state      <= state_next;
         busy       <= (state_next == ST_SCAN);
         hsync      <= !((state_next == ST_SCAN) && (h_phase_next == PH_SYNC));
         vsync      <= !((state_next == ST_SCAN) && (v_phase_next == PH_SYNC));
         active     <= (state_next == ST_SCAN) && (h_phase_next == PH_ACTIVE)
                       && (v_phase_next == PH_ACTIVE);
         frameStart <= start_next;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   // Frame counter bumps on the same edge that raises frameStart.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         frameCnt <= 8'd0;
      else if (start_next)
         frameCnt <= frameCnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl: a small-geometry instance checked every
// cycle against a linear-position model, plus a default 640x480 instance
// checked at hand-computed event times. Honours VGA_FRAME_CNT_EN.
module tb_vga_timing_ctrl;

   localparam int SH_ACT = 8;
   localparam int SH_FP  = 2;
   localparam int SH_SYN = 3;
   localparam int SH_BP  = 2;
   localparam int SH_TOT = 15;
   localparam int SV_ACT = 6;
   localparam int SV_FP  = 2;
   localparam int SV_SYN = 2;
   localparam int SV_BP  = 3;
   localparam int SV_TOT = 13;
   localparam int FRAME  = SH_TOT * SV_TOT;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       pixEnS = 1'b0;
   logic       runS = 1'b0;
   logic       pixEnD = 1'b0;
   logic       runD = 1'b0;
   logic       busyS, hsyncS, vsyncS, activeS, frameStartS;
   logic       busyD, hsyncD, vsyncD, activeD, frameStartD;
   logic [9:0] pixXS, pixYS, pixXD, pixYD;
`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frameCntS, frameCntD;
`endif

   int modeS = 0;
   int modeD = 0;
   int divS = 0;
   int divD = 0;
   int errors = 0;
   int checks = 0;
   bit checkOn = 1'b0;

   bit mScan = 1'b0;
   int mPos = 0;
   bit mStart = 1'b0;
   int mCnt = 0;

   always #5 clock = ~clock;

   vga_timing_ctrl #(
      .H_ACTIVE (SH_ACT), .H_FP (SH_FP), .H_SYNC (SH_SYN), .H_BP (SH_BP),
      .V_ACTIVE (SV_ACT), .V_FP (SV_FP), .V_SYNC (SV_SYN), .V_BP (SV_BP)
   ) dutS (
      .clock      (clock),
      .reset      (reset),
      .pixEn      (pixEnS),
      .run        (runS),
      .busy       (busyS),
      .hsync      (hsyncS),
      .vsync      (vsyncS),
      .active     (activeS),
      .pixX       (pixXS),
      .pixY       (pixYS),
      .frameStart (frameStartS)
`ifdef VGA_FRAME_CNT_EN
      ,.frameCnt  (frameCntS)
`endif
   );

   vga_timing_ctrl dutD (
      .clock      (clock),
      .reset      (reset),
      .pixEn      (pixEnD),
      .run        (runD),
      .busy       (busyD),
      .hsync      (hsyncD),
      .vsync      (vsyncD),
      .active     (activeD),
      .pixX       (pixXD),
      .pixY       (pixYD),
      .frameStart (frameStartD)
`ifdef VGA_FRAME_CNT_EN
      ,.frameCnt  (frameCntD)
`endif
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic applyStimulus(input bit runVal, input int modeVal);
      runS  = runVal;
      modeS = modeVal;
   endtask

   // Pixel-enable generators: mode 1 = every clock, 4 = one-in-four, else held low.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         divS = (divS + 1) % 4;
         divD = (divD + 1) % 4;
         pixEnS = (modeS == 1) || (modeS == 4 && divS == 0);
         pixEnD = (modeD == 1) || (modeD == 4 && divD == 0);
      end
   end

   // Model of the small instance: scan position as one linear index into the frame.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mScan  = 1'b0;
         mPos   = 0;
         mStart = 1'b0;
         mCnt   = 0;
      end else begin
         mStart = 1'b0;
         if (pixEnS) begin
            if (!mScan) begin
               if (runS) begin
                  mScan  = 1'b1;
                  mPos   = 0;
                  mStart = 1'b1;
               end
            end else if (mPos == FRAME - 1) begin
               mPos = 0;
               if (runS)
                  mStart = 1'b1;
               else
                  mScan = 1'b0;
            end else begin
               mPos++;
            end
         end
         if (mStart)
            mCnt = (mCnt + 1) % 256;
      end
   end

   task automatic compareModel();
      int x;
      int y;
      x = mScan ? mPos % SH_TOT : 0;
      y = mScan ? mPos / SH_TOT : 0;
      checkOutput("m_busy", busyS, mScan);
      checkOutput("m_pixX", pixXS, x);
      checkOutput("m_pixY", pixYS, y);
      checkOutput("m_hsync", hsyncS,
                  !(mScan && x >= SH_ACT + SH_FP && x < SH_ACT + SH_FP + SH_SYN));
      checkOutput("m_vsync", vsyncS,
                  !(mScan && y >= SV_ACT + SV_FP && y < SV_ACT + SV_FP + SV_SYN));
      checkOutput("m_active", activeS, mScan && x < SH_ACT && y < SV_ACT);
      checkOutput("m_frameStart", frameStartS, mStart);
`ifdef VGA_FRAME_CNT_EN
      checkOutput("m_frameCnt", frameCntS, mCnt);
`endif
   endtask

   // Per-cycle comparison on the falling edge, away from the active edge.
   always @(negedge clock) begin
      if (checkOn)
         compareModel();
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int cntA;
      int cntV;
      int cntH;
      int idleBad;
      int starts;
      int lastX;
      int lastY;
      int evA;
      int evF;
      int evR;
      int evL;
      bit prevH;
      bit prevA;
      int prevY;

      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      checkOn = 1'b1;
      tick();

      $display("[TB] reset state");
      checkOutput("rst_busy", busyS, 0);
      checkOutput("rst_hsync", hsyncS, 1);
      checkOutput("rst_vsync", vsyncS, 1);
      checkOutput("rst_pixX", pixXS, 0);
      checkOutput("rst_frameStart", frameStartS, 0);
      checkOutput("rst_busyD", busyD, 0);

      $display("[TB] default 640x480 first line at one-in-four");
      runD = 1'b1;
      modeD = 4;
      n = 0;
      while (frameStartD !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checkOutput("def_start_seen", frameStartD, 1);
      checkOutput("def_start_x", pixXD, 0);
      checkOutput("def_start_y", pixYD, 0);
      checkOutput("def_start_active", activeD, 1);
      checkOutput("def_start_busy", busyD, 1);
      prevH = 1'b1;
      prevA = 1'b1;
      prevY = 0;
      evA = 0; evF = 0; evR = 0; evL = 0;
      for (int t = 1; t <= 3300; t++) begin
         tick();
         if (t == 1)
            checkOutput("def_start_width", frameStartD, 0);
         if (prevA && !activeD) begin
            evA++;
            checkOutput("def_active_end_x", pixXD, 640);
            checkOutput("def_active_end_t", t, 2560);
         end
         if (prevH && !hsyncD) begin
            evF++;
            checkOutput("def_hsync_fall_x", pixXD, 656);
            checkOutput("def_hsync_fall_t", t, 2624);
         end
         if (!prevH && hsyncD) begin
            evR++;
            checkOutput("def_hsync_rise_x", pixXD, 752);
            checkOutput("def_hsync_rise_t", t, 3008);
         end
         if (int'(pixYD) != prevY) begin
            evL++;
            checkOutput("def_line_y", pixYD, 1);
            checkOutput("def_line_x", pixXD, 0);
            checkOutput("def_line_t", t, 3200);
         end
         prevH = hsyncD;
         prevA = activeD;
         prevY = int'(pixYD);
      end
      checkOutput("def_event_count", evA + evF + evR + evL, 4);
      checkOutput("def_vsync_line1", vsyncD, 1);
      modeD = 0;
      runD = 1'b0;

      $display("[TB] idle with run low");
      applyStimulus(1'b0, 4);
      idleBad = 0;
      repeat (4000) begin
         tick();
         if (busyS !== 1'b0 || hsyncS !== 1'b1 || vsyncS !== 1'b1 || activeS !== 1'b0 ||
             pixXS !== 10'd0 || pixYS !== 10'd0 || frameStartS !== 1'b0)
            idleBad++;
      end
      checkOutput("idle_hold", idleBad, 0);

      $display("[TB] start from idle");
      applyStimulus(1'b1, 4);
      n = 0;
      while (frameStartS !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      checkOutput("start_seen", frameStartS, 1);
      checkOutput("start_x", pixXS, 0);
      checkOutput("start_y", pixYS, 0);
      checkOutput("start_active", activeS, 1);
      checkOutput("start_busy", busyS, 1);
      tick();
      checkOutput("start_width", frameStartS, 0);

      $display("[TB] full frame measurement at one tick per clock");
      applyStimulus(1'b1, 1);
      n = 0;
      while (frameStartS !== 1'b1 && n < 900) begin
         tick();
         n++;
      end
      checkOutput("frame_start_seen", frameStartS, 1);
      n = 0; cntA = 0; cntV = 0; cntH = 0;
      do begin
         if (activeS) cntA++;
         if (!vsyncS) cntV++;
         if (!hsyncS) cntH++;
         tick();
         n++;
      end while (frameStartS !== 1'b1 && n < 400);
      checkOutput("frame_period", n, 195);
      checkOutput("frame_active", cntA, 48);
      checkOutput("frame_vsync_low", cntV, 30);
      checkOutput("frame_hsync_low", cntH, 39);

      $display("[TB] pixEn held low before sync");
      n = 0;
      while (pixXS !== 10'd8 && n < 30) begin
         tick();
         n++;
      end
      checkOutput("freeze_reach_x8", pixXS, 8);
      modeS = 0;
      tick();
      idleBad = 0;
      repeat (50) begin
         tick();
         if (pixXS !== 10'd9 || hsyncS !== 1'b1) idleBad++;
      end
      checkOutput("freeze_hold", idleBad, 0);
      checkOutput("freeze_x", pixXS, 9);
      modeS = 1;
      n = 0;
      while (pixXS === 10'd9 && n < 5) begin
         tick();
         n++;
      end
      checkOutput("freeze_next_x", pixXS, 10);
      checkOutput("freeze_next_hsync", hsyncS, 0);

      $display("[TB] run dropped mid-frame");
      n = 0;
      while (pixYS !== 10'd2 && n < 300) begin
         tick();
         n++;
      end
      checkOutput("drop_reach_y2", pixYS, 2);
      runS = 1'b0;
      n = 0; starts = 0; lastX = 0; lastY = 0;
      do begin
         lastX = int'(pixXS);
         lastY = int'(pixYS);
         tick();
         n++;
         if (frameStartS) starts++;
      end while (busyS !== 1'b0 && n < 400);
      checkOutput("drop_busy", busyS, 0);
      checkOutput("drop_last_x", lastX, 14);
      checkOutput("drop_last_y", lastY, 12);
      checkOutput("drop_no_start", starts, 0);
      checkOutput("drop_idle_x", pixXS, 0);

      $display("[TB] reset during hsync and vsync");
      runS = 1'b1;
      n = 0;
      while (!(pixXS === 10'd11 && pixYS === 10'd8) && n < 500) begin
         tick();
         n++;
      end
      checkOutput("rsync_hsync_low", hsyncS, 0);
      checkOutput("rsync_vsync_low", vsyncS, 0);
      reset = 1'b1;
      tick();
      checkOutput("rsync_hsync", hsyncS, 1);
      checkOutput("rsync_vsync", vsyncS, 1);
      checkOutput("rsync_pixX", pixXS, 0);
      checkOutput("rsync_pixY", pixYS, 0);
      checkOutput("rsync_frameStart", frameStartS, 0);
      checkOutput("rsync_busy", busyS, 0);
`ifdef VGA_FRAME_CNT_EN
      checkOutput("rsync_frameCnt", frameCntS, 0);
`endif
      reset = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         n = 0;
         while (frameStartS !== 1'b1 && n < 300) begin
            tick();
            n++;
         end
         checkOutput("cnt_frame_start", frameStartS, 1);
         checkOutput("cnt_frame_x", pixXS, 0);
`ifdef VGA_FRAME_CNT_EN
         checkOutput("cnt_frameCnt", frameCntS, k);
`endif
         tick();
      end

      checkOn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
